stopwatch_ctrl: RTL

//  Run-control sequencer for the stopwatch counter/display datapath.
//  - Debounces two push-buttons (START/STOP and LAP/RESET) and runs the run/pause/lap/full state machine.
//  - Generates the 10 ms count-enable tick, the synchronous counter-clear pulse and the display lap-freeze.
//  - Sits between the board buttons and the BCD counter; it replaces free-running divider and raw PAUSE/CLR wiring.

---
 rtl/stopwatch_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the stopwatch: button debounce, run/pause/lap/full
// state machine, 10 ms count tick, counter clear pulse and display lap-freeze.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DB_CYC   = 1000000
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       BTN_SS,
  input  logic       BTN_LR,
  input  logic       WARN,
  output logic       TICK,
  output logic       CNT_CLR,
  output logic       FREEZE,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_FULL  = 3'd4
  } state_e;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 32'd1);
  localparam logic [23:0] DB_LAST   = 24'(DB_CYC - 32'd1);

  // Button vectors: bit 0 = START/STOP, bit 1 = LAP/RESET.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       acc_q, acc_d;
  logic [1:0]       ev_q, ev_d;
  logic [1:0][23:0] db_cnt_q, db_cnt_d;

  state_e      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic        tick_q, tick_d;
  logic        clr_q, clr_d;
  logic        frz_q, frz_d;
  logic        ss_ev, lr_ev;
  logic        presc_clr, counting, wrap;

  // Two-flop synchronisers for the raw buttons.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {BTN_LR, BTN_SS};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count while the synced level disagrees with the accepted one;
  // accept after DB_CYC disagreeing samples and flag a rising acceptance.
  always_comb begin
    db_cnt_d = db_cnt_q;
    acc_d    = acc_q;
    ev_d     = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] == acc_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        acc_d[i]    = sync2_q[i];
        ev_d[i]     = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 24'd1;
      end
    end
  end

  // Debounce counters, accepted levels and registered press events.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      db_cnt_q <= '0;
      acc_q    <= '0;
      ev_q     <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      acc_q    <= acc_d;
      ev_q     <= ev_d;
    end
  end

  // Next-state decode; START/STOP wins over a same-cycle LAP/RESET.
  always_comb begin
    ss_ev     = ev_q[0];
    lr_ev     = ev_q[1] & ~ev_q[0];
    state_d   = state_q;
    clr_d     = 1'b0;
    presc_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        presc_clr = 1'b1;
        if (ss_ev)      state_d = S_RUN;
        else if (lr_ev) clr_d   = 1'b1;
      end
      S_RUN: begin
        if (WARN)       state_d = S_FULL;
        else if (ss_ev) state_d = S_PAUSE;
        else if (lr_ev) state_d = S_LAP;
      end
      S_LAP: begin
        if (WARN)       state_d = S_FULL;
        else if (ss_ev) state_d = S_PAUSE;
        else if (lr_ev) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss_ev) begin
          state_d = S_RUN;
        end else if (lr_ev) begin
          state_d   = S_IDLE;
          clr_d     = 1'b1;
          presc_clr = 1'b1;
        end
      end
      S_FULL: begin
        if (lr_ev) begin
          state_d   = S_IDLE;
          clr_d     = 1'b1;
          presc_clr = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        presc_clr = 1'b1;
      end
    endcase
  end

  // Prescaler advances only on edges that stay within RUN/LAP, so the edge
  // leaving for PAUSE/FULL neither loses a partial tick nor emits one.
  always_comb begin
    counting = ((state_q == S_RUN) || (state_q == S_LAP)) &&
               ((state_d == S_RUN) || (state_d == S_LAP));
    wrap     = (presc_q == TICK_LAST);
    presc_d  = presc_q;
    tick_d   = 1'b0;
    frz_d    = (state_d == S_LAP);
    if (presc_clr) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = wrap ? '0 : presc_q + 24'd1;
      tick_d  = wrap;
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      frz_q   <= frz_d;
    end
  end

  assign TICK    = tick_q;
  assign CNT_CLR = clr_q;
  assign FREEZE  = frz_q;
  assign STATE   = state_q;

endmodule
